// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters: registered grant index, one-hot grant, hold timeout.
// Optional macro RR_ARB_LOCK_EN adds a LOCK input that pins the current grant.

module rr_arbiter_16 #(
    parameter int CW       = 8,
    parameter int HOLD_MAX = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [15:0] REQ,
`ifdef RR_ARB_LOCK_EN
    input  logic        LOCK,
`endif
    output logic [15:0] GNT,
    output logic [3:0]  GNT_IDX,
    output logic        GNT_VLD,
    output logic        EXPIRED
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_SAT    = '1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(HOLD_MAX - 1);
    localparam bit            TIMEOUT_EN = (HOLD_MAX != 0);

    state_t        state, state_nxt;
    logic [3:0]    ptr, ptr_nxt;
    logic [3:0]    owner, owner_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic [15:0]   gnt_vec, gnt_vec_nxt;
    logic          timed_out, timed_out_nxt;
    logic [3:0]    win_idx;
    logic          win_vld;
    logic          locked;
    logic          timeout_hit;

`ifdef RR_ARB_LOCK_EN
    assign locked = LOCK;
`else
    assign locked = 1'b0;
`endif

    // Circular priority search starting at ptr; 4-bit addition wraps mod 16.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        for (int off = 0; off < 16; off++) begin
            if (!win_vld && REQ[ptr + 4'(off)]) begin
                win_vld = 1'b1;
                win_idx = ptr + 4'(off);
            end
        end
    end

    assign timeout_hit = TIMEOUT_EN && (hold_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        hold_cnt_nxt  = hold_cnt;
        timed_out_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (EN && win_vld) begin
                    state_nxt    = GRANT;
                    owner_nxt    = win_idx;
                    hold_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (locked) begin
                    // Grant pinned: counter frozen, no release and no timeout.
                    hold_cnt_nxt = hold_cnt;
                end else if (!REQ[owner]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner + 4'd1;
                end else if (timeout_hit) begin
                    state_nxt     = IDLE;
                    ptr_nxt       = owner + 4'd1;
                    timed_out_nxt = 1'b1;
                end else if (hold_cnt != CNT_SAT) begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        gnt_vec_nxt = (state_nxt == GRANT) ? (16'b1 << owner_nxt) : 16'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            gnt_vec   <= '0;
            timed_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt_vec   <= gnt_vec_nxt;
            timed_out <= timed_out_nxt;
        end
    end

    assign GNT     = gnt_vec;
    assign GNT_IDX = owner;
    assign GNT_VLD = (state == GRANT);
    assign EXPIRED = timed_out;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Self-checking bench for rr_arbiter_16: directed table, hand sequences and a random run
// against a cycle-count based reference model (HOLD_MAX = 4).

module tb_rr_arbiter_16;

    localparam int HOLD = 4;
`ifdef RR_ARB_LOCK_EN
    localparam bit HAS_LOCK = 1'b1;
`else
    localparam bit HAS_LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic        lock;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic        expired;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    rr_arbiter_16 #(.CW(8), .HOLD_MAX(HOLD)) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .EN      (en),
        .REQ     (req),
`ifdef RR_ARB_LOCK_EN
        .LOCK    (lock),
`endif
        .GNT     (gnt),
        .GNT_IDX (gnt_idx),
        .GNT_VLD (gnt_vld),
        .EXPIRED (expired)
    );

    // Reference model: owner as an int (-1 = none), held = cycles the grant has been visible.
    int         m_owner;
    logic [3:0] m_last;
    int         m_ptr;
    int         m_held;
    logic       m_exp;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 4'd0;
        m_ptr   = 0;
        m_held  = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
    endtask

    task automatic model_step();
        logic exp_n;
        bit   found;
        exp_n = 1'b0;
        found = 1'b0;
        if (m_owner < 0) begin
            if (en) begin
                for (int k = 0; k < 16; k++) begin
                    int c;
                    c = (m_ptr + k) % 16;
                    if (!found && req[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_last  = 4'(c);
                        m_held  = 1;
                    end
                end
            end
        end else if (HAS_LOCK && lock) begin
            m_held = m_held;
        end else if (!req[m_owner]) begin
            model_release();
        end else if (HOLD != 0 && m_held >= HOLD) begin
            model_release();
            exp_n = 1'b1;
        end else begin
            m_held++;
        end
        m_exp = exp_n;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        logic [15:0] w_gnt;
        w_gnt = (m_owner >= 0) ? (16'b1 << m_owner) : 16'b0;
        check({tag, ".gnt"},     32'(gnt),     32'(w_gnt));
        check({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(m_last));
        check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
        check({tag, ".expired"}, 32'(expired), 32'(m_exp));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model(tag);
        check({tag, ".gnt_now"}, 32'(gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic [15:0] req;
        logic        vld;
        logic [3:0]  idx;
        logic        expd;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [15:0] want_gnt;
        int          want_seq[4];

        // en, req applied before the edge; vld, idx, expired expected after it.
        vecs[0]  = '{1'b0, 16'h0011, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 16'h0011, 1'b0, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 16'h0011, 1'b1, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0011, 1'b1, 4'd0, 1'b0};
        vecs[4]  = '{1'b1, 16'h0010, 1'b0, 4'd0, 1'b0};
        vecs[5]  = '{1'b1, 16'h0011, 1'b1, 4'd4, 1'b0};
        vecs[6]  = '{1'b1, 16'h0011, 1'b1, 4'd4, 1'b0};
        vecs[7]  = '{1'b1, 16'h0011, 1'b1, 4'd4, 1'b0};
        vecs[8]  = '{1'b1, 16'h0011, 1'b1, 4'd4, 1'b0};
        vecs[9]  = '{1'b1, 16'h0011, 1'b0, 4'd4, 1'b1};
        vecs[10] = '{1'b1, 16'h0011, 1'b1, 4'd0, 1'b0};
        vecs[11] = '{1'b1, 16'h0010, 1'b0, 4'd0, 1'b0};
        vecs[12] = '{1'b1, 16'h0008, 1'b1, 4'd3, 1'b0};
        vecs[13] = '{1'b1, 16'h0008, 1'b1, 4'd3, 1'b0};
        vecs[14] = '{1'b1, 16'h0008, 1'b1, 4'd3, 1'b0};
        vecs[15] = '{1'b1, 16'h0008, 1'b1, 4'd3, 1'b0};
        vecs[16] = '{1'b1, 16'h0000, 1'b0, 4'd3, 1'b0};
        vecs[17] = '{1'b1, 16'h0000, 1'b0, 4'd3, 1'b0};

        rst_n = 1'b0;
        en    = 1'b0;
        req   = 16'h0;
        lock  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_model("reset");
        rst_n = 1'b1;

        // Idle with no requests.
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick("idle");

        // Directed table from a fresh reset (ptr = 0).
        async_reset("rst_tbl");
        for (int i = 0; i < 18; i++) begin
            en  = vecs[i].en;
            req = vecs[i].req;
            tick("tbl_model");
            want_gnt = vecs[i].vld ? (16'b1 << vecs[i].idx) : 16'b0;
            check($sformatf("tbl[%0d].vld", i), 32'(gnt_vld), 32'(vecs[i].vld));
            check($sformatf("tbl[%0d].idx", i), 32'(gnt_idx), 32'(vecs[i].idx));
            check($sformatf("tbl[%0d].exp", i), 32'(expired), 32'(vecs[i].expd));
            check($sformatf("tbl[%0d].gnt", i), 32'(gnt),     32'(want_gnt));
        end

        // Two requesters alternate; each owner holds 3 cycles then drops.
        async_reset("rst_alt");
        want_seq = '{0, 4, 0, 4};
        en  = 1'b1;
        req = 16'h0011;
        tick("alt");
        for (int g = 0; g < 4; g++) begin
            check($sformatf("alt[%0d].idx", g), 32'(gnt_idx), 32'(want_seq[g]));
            check($sformatf("alt[%0d].vld", g), 32'(gnt_vld), 32'h1);
            tick("alt");
            tick("alt");
            req = 16'h0011 & ~(16'b1 << want_seq[g]);
            tick("alt");
            check($sformatf("alt[%0d].gap", g), 32'(gnt), 32'h0);
            req = 16'h0011;
            tick("alt");
        end

        // Full rotation with all requesters active, including the wrap back to 0.
        async_reset("rst_rot");
        req = 16'hFFFF;
        tick("rot");
        for (int g = 0; g < 17; g++) begin
            check($sformatf("rot[%0d].idx", g), 32'(gnt_idx), 32'(g % 16));
            check($sformatf("rot[%0d].vld", g), 32'(gnt_vld), 32'h1);
            tick("rot");
            req = 16'hFFFF & ~(16'b1 << (g % 16));
            tick("rot");
            check($sformatf("rot[%0d].gap", g), 32'(gnt_vld), 32'h0);
            req = 16'hFFFF;
            tick("rot");
        end

        // Continuous request from 15: 4 granted cycles, expiry/gap cycle, re-grant.
        async_reset("rst_to");
        req = 16'h8000;
        tick("to");
        check("to.first_idx", 32'(gnt_idx), 32'd15);
        for (int c = 0; c < 3; c++) begin
            tick("to");
            check($sformatf("to.hold[%0d]", c), 32'(gnt_vld), 32'h1);
        end
        tick("to");
        check("to.expired", 32'(expired), 32'h1);
        check("to.gap_gnt", 32'(gnt), 32'h0);
        tick("to");
        check("to.regrant", 32'(gnt), 32'h8000);
        check("to.exp_low", 32'(expired), 32'h0);

        // Reset in the middle of a grant.
        check("mid.vld_before", 32'(gnt_vld), 32'h1);
        async_reset("rst_mid");

`ifdef RR_ARB_LOCK_EN
        // Locked grant survives request drop and timeout, releases after LOCK falls.
        req  = 16'h0004;
        lock = 1'b0;
        tick("lock");
        check("lock.idx", 32'(gnt_idx), 32'd2);
        lock = 1'b1;
        req  = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            tick("lock");
            check($sformatf("lock.hold[%0d]", c), 32'(gnt), 32'h0004);
            check($sformatf("lock.noexp[%0d]", c), 32'(expired), 32'h0);
        end
        lock = 1'b0;
        tick("lock");
        check("lock.release", 32'(gnt_vld), 32'h0);
`endif

        // Randomised run against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r >= 5 && r < 8) req = req ^ (16'b1 << $urandom_range(0, 15));
            else if (r >= 8)     req = 16'($urandom) & 16'($urandom);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) lock = ~lock;
            if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
